rr_hold_arbiter: RTL and testbench

- Parametrised round-robin arbiter for router output ports. Grants one of NUM_REQ input-port requesters and holds the grant for as long as the owner keeps its request high (packet-length hold).
- Replaces the fixed-priority 5-input output arbiter.
- Adds round-robin fairness, zero-bubble handoff between owners, and an encoded grant id for the crossbar select.

---
 rtl/rr_hold_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rr_hold_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// Round-robin output-port arbiter that holds the grant for the owner's whole packet.
// Optional: define ARB_HOLD_LIMIT_EN to force a handoff after HOLD_LIMIT owned cycles.
module rr_hold_arbiter #(
   parameter int NUM_REQ    = 5,
   parameter int HOLD_LIMIT = 16,
   localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IDW-1:0]     gnt_id,
   output logic               busy
);

   typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;

   state_t             r_state;
   logic [IDW-1:0]     r_ptr;
   logic [NUM_REQ-1:0] r_gnt;
   logic [IDW-1:0]     r_gnt_id;
   logic               r_gnt_valid;
   logic               r_busy;

   logic [IDW:0]       w_all;
   logic [IDW:0]       w_oth;
   logic [NUM_REQ-1:0] w_others;
   logic               w_owner_req;
   logic               w_force;
   logic               w_new_grant;

   // First set bit of vec scanning upward from ptr with wrap; returns {found, index}.
   function automatic logic [IDW:0] f_search(input logic [NUM_REQ-1:0] vec,
                                             input logic [IDW-1:0]     ptr);
      logic           found;
      logic [IDW-1:0] idx;
      int unsigned    pos;
      found = 1'b0;
      idx   = {IDW{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(ptr) + i;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end else begin
            pos = pos;
         end
         if (!found && vec[pos]) begin
            found = 1'b1;
            idx   = IDW'(pos);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // Pointer moves to the port after the winner, wrapping at the top index.
   function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] idx);
      if (int'(idx) == NUM_REQ - 1) begin
         return {IDW{1'b0}};
      end else begin
         return idx + {{(IDW-1){1'b0}}, 1'b1};
      end
   endfunction

   function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDW-1:0] idx);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // The current owner is masked out so a release or preemption hands off to someone else.
   assign w_others    = req & ~r_gnt;
   assign w_owner_req = |(req & r_gnt);
   assign w_all       = f_search(req, r_ptr);
   assign w_oth       = f_search(w_others, r_ptr);
   assign w_new_grant = (r_state == ST_IDLE) ? w_all[IDW]
                                             : ((!w_owner_req || w_force) && w_oth[IDW]);

`ifdef ARB_HOLD_LIMIT_EN
   logic [7:0] r_hold_cnt;

   assign w_force = (r_hold_cnt == 8'(HOLD_LIMIT - 1)) && w_owner_req && (|w_others);

   // Owned-cycle counter; restarts on each grant and saturates at the limit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_cnt <= 8'd0;
      end else if (w_new_grant) begin
         r_hold_cnt <= 8'd0;
      end else if ((r_state == ST_OWNED) && (r_hold_cnt < 8'(HOLD_LIMIT - 1))) begin
         r_hold_cnt <= r_hold_cnt + 8'd1;
      end else begin
         r_hold_cnt <= r_hold_cnt;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= {IDW{1'b0}};
         r_gnt       <= {NUM_REQ{1'b0}};
         r_gnt_id    <= {IDW{1'b0}};
         r_gnt_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_all[IDW]) begin
                  r_state     <= ST_OWNED;
                  r_ptr       <= f_next(w_all[IDW-1:0]);
                  r_gnt       <= f_onehot(w_all[IDW-1:0]);
                  r_gnt_id    <= w_all[IDW-1:0];
                  r_gnt_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_state     <= ST_IDLE;
                  r_ptr       <= r_ptr;
                  r_gnt       <= {NUM_REQ{1'b0}};
                  r_gnt_id    <= {IDW{1'b0}};
                  r_gnt_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            ST_OWNED: begin
               if (w_owner_req && !w_force) begin
                  r_state     <= ST_OWNED;
                  r_ptr       <= r_ptr;
                  r_gnt       <= r_gnt;
                  r_gnt_id    <= r_gnt_id;
                  r_gnt_valid <= r_gnt_valid;
                  r_busy      <= r_busy;
               end else if (w_oth[IDW]) begin
                  r_state     <= ST_OWNED;
                  r_ptr       <= f_next(w_oth[IDW-1:0]);
                  r_gnt       <= f_onehot(w_oth[IDW-1:0]);
                  r_gnt_id    <= w_oth[IDW-1:0];
                  r_gnt_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_state     <= ST_IDLE;
                  r_ptr       <= r_ptr;
                  r_gnt       <= {NUM_REQ{1'b0}};
                  r_gnt_id    <= {IDW{1'b0}};
                  r_gnt_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_ptr       <= {IDW{1'b0}};
               r_gnt       <= {NUM_REQ{1'b0}};
               r_gnt_id    <= {IDW{1'b0}};
               r_gnt_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gnt_valid;
   assign gnt_id    = r_gnt_id;
   assign busy      = r_busy;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter (NUM_REQ=5, HOLD_LIMIT=4), directed vectors.
module tb_rr_hold_arbiter;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [2:0]   gnt_id;
   logic         busy;

   typedef struct {
      logic [N-1:0] gnt;
      logic [2:0]   id;
      string        name;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   event chk_ev;

   rr_hold_arbiter #(.NUM_REQ(N), .HOLD_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .gnt_valid(gnt_valid), .gnt_id(gnt_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: pops one expectation per falling edge (or on demand) and compares.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or chk_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, "gnt",       32'(gnt),       32'(e.gnt));
            check(e.name, "gnt_valid", 32'(gnt_valid), 32'(|e.gnt));
            check(e.name, "gnt_id",    32'(gnt_id),    32'(e.id));
            check(e.name, "busy",      32'(busy),      32'(|e.gnt));
         end
      end
   end

   // Drive req before the edge; expect outputs g/id after it.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] g, input logic [2:0] id, input string nm);
      exp_t e;
      @(negedge clk);
      req = r;
      @(posedge clk);
      e.gnt = g; e.id = id; e.name = nm;
      q.push_back(e);
   endtask

   task automatic check_now(input string nm);
      exp_t e;
      e.gnt = '0; e.id = 3'd0; e.name = nm;
      q.push_back(e);
      -> chk_ev;
      #1;
   endtask

   initial begin
      #2 rst = 1'b0;
      #1 check_now("rst_initial");
      @(negedge clk);
      rst = 1'b1;
      step(5'b00000, 5'b00000, 3'd0, "idle_after_rst");

      // single requester, grant then release
      step(5'b00100, 5'b00100, 3'd2, "single_grant");
      for (int i = 0; i < 4; i++) step(5'b00100, 5'b00100, 3'd2, "single_hold");
      step(5'b00000, 5'b00000, 3'd0, "single_release");
      step(5'b00000, 5'b00000, 3'd0, "single_idle");

      // asynchronous reset mid-grant
      step(5'b00100, 5'b00100, 3'd2, "pre_rst_grant");
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check_now("async_rst_midgrant");
      @(negedge clk);
      req = 5'b00000;
      rst = 1'b1;
      step(5'b00000, 5'b00000, 3'd0, "post_rst_idle0");
      step(5'b00000, 5'b00000, 3'd0, "post_rst_idle1");

      // round-robin with zero-bubble handoffs 0,1,2,3,4,0
      for (int i = 0; i < 3; i++) step(5'b11111, 5'b00001, 3'd0, "rr_own0");
      step(5'b11110, 5'b00010, 3'd1, "rr_hand1");
      for (int i = 0; i < 2; i++) step(5'b11111, 5'b00010, 3'd1, "rr_own1");
      step(5'b11101, 5'b00100, 3'd2, "rr_hand2");
      for (int i = 0; i < 2; i++) step(5'b11111, 5'b00100, 3'd2, "rr_own2");
      step(5'b11011, 5'b01000, 3'd3, "rr_hand3");
      for (int i = 0; i < 2; i++) step(5'b11111, 5'b01000, 3'd3, "rr_own3");
      step(5'b10111, 5'b10000, 3'd4, "rr_hand4");
      for (int i = 0; i < 2; i++) step(5'b11111, 5'b10000, 3'd4, "rr_own4");
      step(5'b01111, 5'b00001, 3'd0, "rr_wrap0");
      step(5'b00000, 5'b00000, 3'd0, "rr_release");

      // wrap and skip: grant 3 leaves ptr=4
      step(5'b01000, 5'b01000, 3'd3, "wrap_grant3");
      step(5'b00000, 5'b00000, 3'd0, "wrap_rel3");
      step(5'b00011, 5'b00001, 3'd0, "wrap_to0");
      step(5'b00011, 5'b00001, 3'd0, "wrap_hold0");
      step(5'b00010, 5'b00010, 3'd1, "skip_to1");
      step(5'b00000, 5'b00000, 3'd0, "skip_release");

      // a pulse during ownership is never granted
      step(5'b00010, 5'b00010, 3'd1, "nolatch_own1");
      step(5'b10010, 5'b00010, 3'd1, "nolatch_pulse4");
      step(5'b00010, 5'b00010, 3'd1, "nolatch_hold");
      step(5'b00000, 5'b00000, 3'd0, "nolatch_idle");

      // hold limit: port 1 owns, port 3 competes
      step(5'b00010, 5'b00010, 3'd1, "hold_own1");
      for (int i = 0; i < 3; i++) step(5'b01010, 5'b00010, 3'd1, "hold_keep1");
`ifdef ARB_HOLD_LIMIT_EN
      step(5'b01010, 5'b01000, 3'd3, "hold_force3");
      step(5'b01000, 5'b01000, 3'd3, "hold_own3");
`else
      step(5'b01010, 5'b00010, 3'd1, "hold_nolimit1");
      step(5'b01010, 5'b00010, 3'd1, "hold_nolimit1b");
      step(5'b01000, 5'b01000, 3'd3, "hold_rel_to3");
`endif
      step(5'b00000, 5'b00000, 3'd0, "hold_release");

      // no competitor: grant kept past the limit
      step(5'b00010, 5'b00010, 3'd1, "solo_own1");
      for (int i = 0; i < 7; i++) step(5'b00010, 5'b00010, 3'd1, "solo_keep1");
      step(5'b00000, 5'b00000, 3'd0, "solo_release");

      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached without finishing");
      $fatal(1, "timeout");
   end
endmodule
